pipe_hazard_ctrl: RTL and testbench

Central hazard, forwarding and stall controller for the 5-stage RV32 pipeline, placed beside the ID stage and driving the stall and flush inputs of `ifecth` and the pipeline registers. It tracks in-flight destination registers in a parametrised scoreboard and generates operand-forwarding selects. It also handles load-use stalls, branch-mispredict flushes, and whole-pipeline freezes while the data memory is not ready. It replaces the current fixed, hazard-free pipeline wiring with a generalised one whose depth is set by `FWD_DEPTH`.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 12 +
 rtl/pipe_hazard_ctrl_sb.sv | 47 ++++
 rtl/pipe_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        HZ_RUN      = 1'b0,
        HZ_MEM_WAIT = 1'b1
    } hz_state_e;

    // Forwarding select that picks the register file.
    localparam int FWD_RF = 0;

endpackage

// File: rtl/pipe_hazard_ctrl_sb.sv
// hazard_sb: in-flight destination scoreboard; entry 0 is EX, higher entries are older stages.
module hazard_sb #(
    parameter int RFIDX_WIDTH = 5,
    parameter int FWD_DEPTH   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   shift_en,
    input  logic                   in_valid,
    input  logic [RFIDX_WIDTH-1:0] in_rd,
    input  logic                   in_load,
    input  logic [RFIDX_WIDTH-1:0] rs1_index,
    input  logic [RFIDX_WIDTH-1:0] rs2_index,
    output logic [FWD_DEPTH-1:0]   rs1_hit,
    output logic [FWD_DEPTH-1:0]   rs2_hit,
    output logic                   ex_is_load
);

    logic [FWD_DEPTH-1:0]                  vld_pipe;
    logic [FWD_DEPTH-1:0][RFIDX_WIDTH-1:0] rd_pipe;
    logic [FWD_DEPTH-1:0]                  ld_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            rd_pipe  <= '0;
            ld_pipe  <= '0;
        end else if (shift_en) begin
            vld_pipe[0] <= in_valid;
            rd_pipe[0]  <= in_rd;
            ld_pipe[0]  <= in_load;
            for (int i = 1; i < FWD_DEPTH; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                rd_pipe[i]  <= rd_pipe[i-1];
                ld_pipe[i]  <= ld_pipe[i-1];
            end
        end
    end

    for (genvar k = 0; k < FWD_DEPTH; k++) begin : g_cmp
        assign rs1_hit[k] = vld_pipe[k] & (rd_pipe[k] == rs1_index);
        assign rs2_hit[k] = vld_pipe[k] & (rd_pipe[k] == rs2_index);
    end

    assign ex_is_load = vld_pipe[0] & ld_pipe[0];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and memory-freeze controller for the 5-stage pipeline.
// Define HAZARD_PERF_EN to add saturating stall/freeze/flush perf counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int RFIDX_WIDTH = 5,
    parameter int FWD_DEPTH   = 3,
    parameter int MEM_TIMEOUT = 64,
    localparam int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   pc_rst,
    input  logic                   id_valid,
    input  logic [RFIDX_WIDTH-1:0] id_rs1_index,
    input  logic [RFIDX_WIDTH-1:0] id_rs2_index,
    input  logic                   id_rs1_used,
    input  logic                   id_rs2_used,
    input  logic [RFIDX_WIDTH-1:0] id_rd_index,
    input  logic                   id_reg_write,
    input  logic                   id_mem_read,
    input  logic                   ex_predict_fail,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    output logic                   stall_front,
    output logic                   bubble_ex,
    output logic                   flush_front,
    output logic                   freeze,
    output logic [SEL_W-1:0]       fwd_rs1_sel,
    output logic [SEL_W-1:0]       fwd_rs2_sel,
    output logic                   mem_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]            perf_stall_cyc,
    output logic [31:0]            perf_freeze_cyc,
    output logic [31:0]            perf_flush_cnt
`endif
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_d;

    logic [FWD_DEPTH-1:0] rs1_hit, rs2_hit;
    logic                 ex_is_load;
    logic                 rs1_live, rs2_live, load_use, sb_in_valid;

    assign rs1_live = id_rs1_used & (id_rs1_index != '0);
    assign rs2_live = id_rs2_used & (id_rs2_index != '0);

    hazard_sb #(
        .RFIDX_WIDTH(RFIDX_WIDTH),
        .FWD_DEPTH  (FWD_DEPTH)
    ) u_sb (
        .clk       (clk),
        .rst       (pc_rst),
        .shift_en  (~freeze),
        .in_valid  (sb_in_valid),
        .in_rd     (id_rd_index),
        .in_load   (id_mem_read),
        .rs1_index (id_rs1_index),
        .rs2_index (id_rs2_index),
        .rs1_hit   (rs1_hit),
        .rs2_hit   (rs2_hit),
        .ex_is_load(ex_is_load)
    );

    // Youngest matching stage wins: scan oldest to youngest so the last hit sticks.
    always_comb begin
        fwd_rs1_sel = SEL_W'(FWD_RF);
        fwd_rs2_sel = SEL_W'(FWD_RF);
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (rs1_live && rs1_hit[k]) fwd_rs1_sel = SEL_W'(k + 1);
            if (rs2_live && rs2_hit[k]) fwd_rs2_sel = SEL_W'(k + 1);
        end
    end

    assign load_use = ex_is_load & ((rs1_live & rs1_hit[0]) | (rs2_live & rs2_hit[0]));

    // A mispredict kills the wrong-path ID instruction, so its load-use stall is moot.
    assign flush_front = ex_predict_fail & ~freeze;
    assign stall_front = load_use & ~ex_predict_fail;
    assign bubble_ex   = stall_front;
    assign sb_in_valid = id_valid & id_reg_write & (id_rd_index != '0) & ~bubble_ex & ~flush_front;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        freeze  = mem_req & ~mem_ready;
        case (state_q)
            HZ_RUN: begin
                if (mem_req && !mem_ready) state_d = HZ_MEM_WAIT;
            end
            HZ_MEM_WAIT: begin
                freeze = 1'b1;
                cnt_d  = cnt_q;
                if (mem_ready) state_d = HZ_RUN;
                else if (cnt_q != CNT_W'(MEM_TIMEOUT)) cnt_d = cnt_q + 1'b1;
            end
            default: state_d = HZ_RUN;
        endcase
        err_d = mem_err | (cnt_d == CNT_W'(MEM_TIMEOUT));
    end

    always_ff @(posedge clk or posedge pc_rst) begin
        if (pc_rst) begin
            state_q <= HZ_RUN;
            cnt_q   <= '0;
            mem_err <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_err <= err_d;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge pc_rst) begin
        if (pc_rst) begin
            perf_stall_cyc  <= '0;
            perf_freeze_cyc <= '0;
            perf_flush_cnt  <= '0;
        end else begin
            if (stall_front && perf_stall_cyc != '1)  perf_stall_cyc  <= perf_stall_cyc + 1'b1;
            if (freeze && perf_freeze_cyc != '1)      perf_freeze_cyc <= perf_freeze_cyc + 1'b1;
            if (flush_front && perf_flush_cnt != '1)  perf_flush_cnt  <= perf_flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: per-cycle vector table plus freeze/timeout/reset sequences.
module tb_pipe_hazard_ctrl;

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       wr, ld, pf, mreq, mrdy;
        logic       stall, bub, flush, frz;
        logic [1:0] s1, s2;
        logic       err;
    } vec_t;

    logic       clk = 1'b0;
    logic       pc_rst;
    logic       id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_mem_read;
    logic [4:0] id_rs1_index, id_rs2_index, id_rd_index;
    logic       ex_predict_fail, mem_req, mem_ready;
    logic       stall_front, bubble_ex, flush_front, freeze, mem_err;
    logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cyc, perf_freeze_cyc, perf_flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.RFIDX_WIDTH(5), .FWD_DEPTH(3), .MEM_TIMEOUT(2)) dut (
        .clk            (clk),
        .pc_rst         (pc_rst),
        .id_valid       (id_valid),
        .id_rs1_index   (id_rs1_index),
        .id_rs2_index   (id_rs2_index),
        .id_rs1_used    (id_rs1_used),
        .id_rs2_used    (id_rs2_used),
        .id_rd_index    (id_rd_index),
        .id_reg_write   (id_reg_write),
        .id_mem_read    (id_mem_read),
        .ex_predict_fail(ex_predict_fail),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .stall_front    (stall_front),
        .bubble_ex      (bubble_ex),
        .flush_front    (flush_front),
        .freeze         (freeze),
        .fwd_rs1_sel    (fwd_rs1_sel),
        .fwd_rs2_sel    (fwd_rs2_sel),
        .mem_err        (mem_err)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cyc (perf_stall_cyc),
        .perf_freeze_cyc(perf_freeze_cyc),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        id_valid        = r.v;
        id_rs1_index    = r.rs1;
        id_rs1_used     = r.u1;
        id_rs2_index    = r.rs2;
        id_rs2_used     = r.u2;
        id_rd_index     = r.rd;
        id_reg_write    = r.wr;
        id_mem_read     = r.ld;
        ex_predict_fail = r.pf;
        mem_req         = r.mreq;
        mem_ready       = r.mrdy;
    endtask

    task automatic chk_all(input string tag, input vec_t r);
        chk({tag, "_stall"},  32'(stall_front), 32'(r.stall));
        chk({tag, "_bubble"}, 32'(bubble_ex),   32'(r.bub));
        chk({tag, "_flush"},  32'(flush_front), 32'(r.flush));
        chk({tag, "_freeze"}, 32'(freeze),      32'(r.frz));
        chk({tag, "_sel1"},   32'(fwd_rs1_sel), 32'(r.s1));
        chk({tag, "_sel2"},   32'(fwd_rs2_sel), 32'(r.s2));
        chk({tag, "_err"},    32'(mem_err),     32'(r.err));
    endtask

    // Fields: v rs1 u1 rs2 u2 rd wr ld pf mreq mrdy | stall bub flush frz s1 s2 err
    vec_t tbl[15];
    vec_t h;

    initial begin
        tbl[0]  = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[1]  = '{1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[2]  = '{1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0};
        tbl[3]  = '{1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 1'b0};
        tbl[4]  = '{1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd2, 1'b0};
        tbl[5]  = '{1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd7,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0};
        tbl[6]  = '{1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0};
        tbl[7]  = '{1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0};
        tbl[8]  = '{1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0};
        tbl[9]  = '{1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[10] = '{1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[11] = '{1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0};
        tbl[12] = '{1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0};
        tbl[13] = '{1'b0, 5'd9, 1'b0, 5'd9, 1'b0, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[14] = '{1'b1, 5'd3, 1'b1, 5'd9, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};

        pc_rst = 1'b1;
        drive(tbl[0]);
        repeat (2) @(posedge clk);
        #1 pc_rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            chk_all($sformatf("r%0d", i), tbl[i]);
            @(posedge clk);
            #1;
        end

        // Put x10 into EX.
        h = tbl[0];
        h.v = 1'b1; h.rd = 5'd10; h.wr = 1'b1;
        drive(h);
        @(posedge clk); #1;

        // Three not-ready memory cycles; ID writes x11 which must not enter.
        h.rs1 = 5'd10; h.u1 = 1'b1; h.rs2 = 5'd11; h.u2 = 1'b1; h.rd = 5'd11;
        h.mreq = 1'b1; h.mrdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            h.pf = (c != 0);
            drive(h);
            @(negedge clk);
            chk($sformatf("frz%0d_freeze", c), 32'(freeze), 32'd1);
            chk($sformatf("frz%0d_sel1", c), 32'(fwd_rs1_sel), 32'd1);
            chk($sformatf("frz%0d_sel2", c), 32'(fwd_rs2_sel), 32'd0);
            chk($sformatf("frz%0d_flush", c), 32'(flush_front), 32'd0);
            chk($sformatf("frz%0d_err", c), 32'(mem_err), 32'd0);
            @(posedge clk); #1;
        end

        // Ready cycle: scoreboard still held, timeout flag now raised.
        h.mrdy = 1'b1;
        drive(h);
        @(negedge clk);
        chk("rdy_sel1", 32'(fwd_rs1_sel), 32'd1);
        chk("rdy_err", 32'(mem_err), 32'd1);
        @(posedge clk); #1;

        // Held mispredict acts on the first unfrozen cycle.
        h.mreq = 1'b0;
        drive(h);
        @(negedge clk);
        chk("unfrz_freeze", 32'(freeze), 32'd0);
        chk("unfrz_flush", 32'(flush_front), 32'd1);
        chk("unfrz_sel1", 32'(fwd_rs1_sel), 32'd1);
        chk("unfrz_err", 32'(mem_err), 32'd1);
        @(posedge clk); #1;

        h.pf = 1'b0; h.wr = 1'b0;
        drive(h);
        @(negedge clk);
        chk("post_sel1", 32'(fwd_rs1_sel), 32'd2);
        chk("post_sel2", 32'(fwd_rs2_sel), 32'd0);
        chk("post_flush", 32'(flush_front), 32'd0);
        chk("post_err", 32'(mem_err), 32'd1);
        @(posedge clk); #1;

        // Enter MEM_WAIT again, then reset mid-wait.
        h.mreq = 1'b1; h.mrdy = 1'b0;
        drive(h);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wait_freeze", 32'(freeze), 32'd1);
        chk("wait_err", 32'(mem_err), 32'd1);
        h.mreq = 1'b0;
        drive(h);
        #2 pc_rst = 1'b1;
        #1;
        chk("rst_err_async", 32'(mem_err), 32'd0);
        #1 pc_rst = 1'b0;
        @(negedge clk);
        chk("rst_freeze", 32'(freeze), 32'd0);
        chk("rst_sel1", 32'(fwd_rs1_sel), 32'd0);
        chk("rst_sel2", 32'(fwd_rs2_sel), 32'd0);
        chk("rst_stall", 32'(stall_front), 32'd0);
        chk("rst_flush", 32'(flush_front), 32'd0);
        chk("rst_err", 32'(mem_err), 32'd0);
`ifdef HAZARD_PERF_EN
        chk("rst_perf_stall", perf_stall_cyc, 32'd0);
        chk("rst_perf_freeze", perf_freeze_cyc, 32'd0);
        chk("rst_perf_flush", perf_flush_cnt, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
